gate_match_monitor: RTL and testbench

Parametrised, registered successor to the team's small gate-level ones detectors (the "exactly one" and "none set" gate structures). It samples a WIDTH-bit input vector and evaluates a run-time selectable condition: exactly-one, at-least-one, majority or odd parity. It also reports the population count and a zero flag. The match result is debounced into a `stable` flag, and rising edges of the match are counted. It sits between raw switch/gate stimulus and downstream logic that needs clean, cycle-aligned condition flags.

---
 rtl/gate_match_monitor.sv | 148 ++++++++++++++
 tb/tb_gate_match_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_match_monitor.sv
// Registered condition monitor over a WIDTH-bit channel vector:
// selectable match test, popcount, zero flag, debounce and event count.
module gate_match_monitor #(
   parameter int WIDTH         = 3,
   parameter int STABLE_CYCLES = 4,
   parameter int EVT_W         = 8,
   localparam int CW           = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_evt,
   output logic             match,
   output logic             zero,
   output logic [CW-1:0]    ones_cnt,
   output logic             stable,
   output logic             match_rise,
   output logic [EVT_W-1:0] evt_cnt
);

   localparam int RW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      STABLE
   } state_t;

   logic [WIDTH-1:0] din_q;
   logic [1:0]       mode_q;
   logic [CW-1:0]    pop;
   logic             hit;
   logic             rise;
   state_t           state;
   state_t           state_nx;
   logic [RW-1:0]    run_cnt;
   logic [RW-1:0]    run_nx;

   // Stage 1: data and mode travel together so a mode change stays aligned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q  <= '0;
         mode_q <= 2'b00;
      end else if (en) begin
         din_q  <= din;
         mode_q <= mode;
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + CW'(din_q[i]);
      end
   end

   always_comb begin
      hit = 1'b0;
      case (mode_q)
         2'b00:   hit = (pop == CW'(1));
         2'b01:   hit = (pop != '0);
         2'b10:   hit = ({pop, 1'b0} > (CW + 1)'(WIDTH));
         default: hit = ^din_q;
      endcase
   end

   assign rise = en & hit & ~match;

   // Stage 2: registered flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match      <= 1'b0;
         zero       <= 1'b0;
         ones_cnt   <= '0;
         match_rise <= 1'b0;
      end else begin
         match_rise <= 1'b0;
         if (en) begin
            match      <= hit;
            zero       <= (din_q == '0);
            ones_cnt   <= pop;
            match_rise <= rise;
         end
      end
   end

   // An explicit clear is honoured even while sampling is paused
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_cnt <= '0;
      end else if (clr_evt) begin
         evt_cnt <= '0;
      end else if (rise && (evt_cnt != '1)) begin
         evt_cnt <= evt_cnt + EVT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         run_cnt <= '0;
      end else begin
         state   <= state_nx;
         run_cnt <= run_nx;
      end
   end

   always_comb begin
      state_nx = state;
      run_nx   = run_cnt;
      if (!en) begin
         state_nx = IDLE;
         run_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = TRACK;
               run_nx   = '0;
            end
            TRACK: begin
               if (hit != match) begin
                  run_nx = '0;
               end else if (run_cnt == RW'(STABLE_CYCLES - 1)) begin
                  state_nx = STABLE;
                  run_nx   = '0;
               end else begin
                  run_nx = run_cnt + RW'(1);
               end
            end
            STABLE: begin
               if (hit != match) begin
                  state_nx = TRACK;
                  run_nx   = '0;
               end
            end
            default: begin
               state_nx = IDLE;
               run_nx   = '0;
            end
         endcase
      end
   end

   assign stable = (state == STABLE);

endmodule

// File: tb/tb_gate_match_monitor.sv
// Scoreboard bench for gate_match_monitor (WIDTH=3, STABLE_CYCLES=4,
// EVT_W=2): stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_gate_match_monitor;

   localparam int WIDTH = 3;
   localparam int SC    = 4;
   localparam int EVT_W = 2;
   localparam int CW    = 2;

   localparam logic [5:0] S_M   = 6'b000001;
   localparam logic [5:0] S_Z   = 6'b000010;
   localparam logic [5:0] S_O   = 6'b000100;
   localparam logic [5:0] S_S   = 6'b001000;
   localparam logic [5:0] S_R   = 6'b010000;
   localparam logic [5:0] S_E   = 6'b100000;
   localparam logic [5:0] S_ALL = 6'b111111;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] din;
   logic             clr_evt;
   logic             match;
   logic             zero;
   logic [CW-1:0]    ones_cnt;
   logic             stable;
   logic             match_rise;
   logic [EVT_W-1:0] evt_cnt;

   gate_match_monitor #(
      .WIDTH(WIDTH),
      .STABLE_CYCLES(SC),
      .EVT_W(EVT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .din(din),
      .clr_evt(clr_evt),
      .match(match),
      .zero(zero),
      .ones_cnt(ones_cnt),
      .stable(stable),
      .match_rise(match_rise),
      .evt_cnt(evt_cnt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int unsigned cyc;
      string       tag;
      logic [5:0]  sel;
      logic        m;
      logic        z;
      logic [1:0]  o;
      logic        s;
      logic        r;
      logic [1:0]  e;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   logic [7:0] mt [4];
   logic [1:0] ot [8];
   logic [1:0] sat [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int unsigned dly, input string tag,
                       input logic [5:0] sel, input logic m, input logic z,
                       input logic [1:0] o, input logic s, input logic r,
                       input logic [1:0] e);
      exp_t x;
      x.cyc = cyc + dly;
      x.tag = tag;
      x.sel = sel;
      x.m   = m;
      x.z   = z;
      x.o   = o;
      x.s   = s;
      x.r   = r;
      x.e   = e;
      sb.push_back(x);
   endtask

   task automatic chk(input string tag, input string f,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s.%s at cycle %0d: got %0d, expected %0d",
                    tag, f, cyc, act, exp);
   endtask

   task automatic check_entry(input exp_t x);
      if (x.sel[0]) chk(x.tag, "match", 8'(match), 8'(x.m));
      if (x.sel[1]) chk(x.tag, "zero", 8'(zero), 8'(x.z));
      if (x.sel[2]) chk(x.tag, "ones_cnt", 8'(ones_cnt), 8'(x.o));
      if (x.sel[3]) chk(x.tag, "stable", 8'(stable), 8'(x.s));
      if (x.sel[4]) chk(x.tag, "match_rise", 8'(match_rise), 8'(x.r));
      if (x.sel[5]) chk(x.tag, "evt_cnt", 8'(evt_cnt), 8'(x.e));
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc < cyc) begin
            checks++;
            $display("FAIL %s missed: due cycle %0d, now %0d",
                     sb[i].tag, sb[i].cyc, cyc);
            sb.delete(i);
         end else if (sb[i].cyc == cyc) begin
            check_entry(sb[i]);
            sb.delete(i);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      mt[0] = 8'b0001_0110;
      mt[1] = 8'b1111_1110;
      mt[2] = 8'b1110_1000;
      mt[3] = 8'b1001_0110;
      ot[0] = 2'd0; ot[1] = 2'd1; ot[2] = 2'd1; ot[3] = 2'd2;
      ot[4] = 2'd1; ot[5] = 2'd2; ot[6] = 2'd2; ot[7] = 2'd3;
      sat[0] = 2'd1; sat[1] = 2'd2; sat[2] = 2'd3;
      sat[3] = 2'd3; sat[4] = 2'd3;

      rst = 1'b1; en = 1'b0; clr_evt = 1'b0; mode = 2'b00; din = '0;
      tick();
      tick();
      rst = 1'b0;
      push(0, "reset", S_ALL, 0, 0, 0, 0, 0, 0);
      tick();

      // mode sweep
      for (int m = 0; m < 4; m++) begin
         for (int d = 0; d < 8; d++) begin
            en = 1'b1; mode = 2'(m); din = 3'(d);
            push(2, "sweep", S_M | S_Z | S_O, mt[m][d], (d == 0),
                 ot[d], 0, 0, 0);
            tick();
         end
      end

      // debounce
      mode = 2'b00; din = 3'b000;
      repeat (4) tick();
      clr_evt = 1'b1;
      push(1, "clr", S_M | S_E, 0, 0, 0, 0, 0, 0);
      tick();
      clr_evt = 1'b0;
      tick();
      din = 3'b001;
      push(1, "deb_pre", S_M | S_R, 0, 0, 0, 0, 0, 0);
      push(2, "deb_rise", S_M | S_R | S_S | S_E, 1, 0, 0, 0, 1, 1);
      push(3, "deb_pulse", S_R | S_S, 0, 0, 0, 0, 0, 0);
      push(5, "deb_wait", S_S, 0, 0, 0, 0, 0, 0);
      push(6, "deb_stable", S_M | S_S, 1, 0, 0, 1, 0, 0);
      repeat (6) tick();
      din = 3'b011;
      push(1, "deb_hold", S_M | S_S, 1, 0, 0, 1, 0, 0);
      push(2, "deb_drop", S_M | S_S | S_R, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      din = 3'b000;
      repeat (4) tick();

      // event saturation
      clr_evt = 1'b1;
      push(1, "sat_clr", S_E, 0, 0, 0, 0, 0, 0);
      tick();
      clr_evt = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         din = 3'b001;
         push(2, "sat_rise", S_M | S_R | S_E, 1, 0, 0, 0, 1, sat[k]);
         tick();
         tick();
         din = 3'b000;
         tick();
         tick();
      end
      din = 3'b001;
      push(2, "clr_rise", S_M | S_R | S_E, 1, 0, 0, 0, 1, 0);
      tick();
      clr_evt = 1'b1;
      tick();
      clr_evt = 1'b0;

      // enable gating
      repeat (4) tick();
      push(0, "gate_pre", S_M | S_S, 1, 0, 0, 1, 0, 0);
      en = 1'b0;
      din = 3'b110;
      push(1, "gate", S_ALL, 1, 0, 1, 0, 0, 0);
      tick();
      din = 3'b010;
      push(1, "gate", S_ALL, 1, 0, 1, 0, 0, 0);
      tick();
      din = 3'b111;
      push(1, "gate", S_ALL, 1, 0, 1, 0, 0, 0);
      tick();
      en = 1'b1;
      din = 3'b001;
      for (int j = 1; j <= 4; j++) begin
         push(j, "regate_wait", S_M | S_S | S_R, 1, 0, 0, 0, 0, 0);
      end
      push(5, "regate_stable", S_M | S_S, 1, 0, 0, 1, 0, 0);
      repeat (5) tick();

      // mode switch with data held
      mode = 2'b00; din = 3'b111;
      repeat (4) tick();
      mode = 2'b01;
      push(1, "msw_pre", S_M | S_R, 0, 0, 0, 0, 0, 0);
      push(2, "msw_rise", S_M | S_R | S_E | S_O, 1, 0, 3, 0, 1, 1);
      push(3, "msw_pulse", S_M | S_R, 1, 0, 0, 0, 0, 0);
      repeat (6) tick();
      push(0, "pre_rst", S_M | S_S | S_E, 1, 0, 0, 1, 0, 1);
      tick();

      // asynchronous reset mid-run
      rst = 1'b1;
      push(0, "async_rst", S_ALL, 0, 0, 0, 0, 0, 0);
      tick();
      push(0, "rst_hold", S_ALL, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (3) tick();

      foreach (sb[i]) begin
         checks++;
         $display("FAIL %s never checked (due cycle %0d)", sb[i].tag, sb[i].cyc);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
